// File: rtl/md_issue.sv
// Multiply/divide issue unit: hands MD ops to an external responder and owns HI/LO.
// Define MD_ISSUE_MADD_EN to enable MADD/MADDU, which accumulate into {hi,lo}.
module md_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [2:0]  e_op,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        d_md,
  output logic        md_req,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_ack,
  input  logic        md_rvalid,
  input  logic [31:0] md_rhi,
  input  logic [31:0] md_rlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        div0,
  output logic        err
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;
  localparam logic [2:0] OpMadd  = 3'd6;
  localparam logic [2:0] OpMaddu = 3'd7;

`ifdef MD_ISSUE_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      state_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic        req_q;
  logic        div0_q;
  logic        err_q;
`ifdef MD_ISSUE_MADD_EN
  logic        madd_q;
  logic [63:0] acc_sum;
`endif

  logic is_mul, is_div, is_madd, div_zero, req_op, issue_op;

  always_comb begin
    is_mul   = (e_op == OpMult) || (e_op == OpMultu);
    is_div   = (e_op == OpDiv)  || (e_op == OpDivu);
    is_madd  = (e_op == OpMadd) || (e_op == OpMaddu);
    div_zero = is_div && (e_b == 32'd0);
    req_op   = is_mul || is_div || (is_madd && MaddEn);
    issue_op = req_op && !div_zero;
  end

`ifdef MD_ISSUE_MADD_EN
  assign acc_sum = {hi_q, lo_q} + {md_rhi, md_rlo};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
      req_q   <= 1'b0;
      div0_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MD_ISSUE_MADD_EN
      madd_q  <= 1'b0;
`endif
    end else begin
      div0_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (e_valid) begin
            if (is_madd && !MaddEn) begin
              err_q <= 1'b1;
            end else if (div_zero) begin
              div0_q <= 1'b1;
            end else if (e_op == OpMthi) begin
              hi_q <= e_a;
            end else if (e_op == OpMtlo) begin
              lo_q <= e_a;
            end else begin
              // MADD/MADDU reuse the MULT/MULTU responder encodings via the low bit.
              op_q    <= is_madd ? {1'b0, e_op[0]} : e_op[1:0];
              a_q     <= e_a;
              b_q     <= e_b;
              req_q   <= 1'b1;
              state_q <= StIssue;
`ifdef MD_ISSUE_MADD_EN
              madd_q  <= is_madd;
`endif
            end
          end
        end
        StIssue: begin
          if (e_valid) err_q <= 1'b1;
          if (md_ack) begin
            req_q   <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (e_valid) err_q <= 1'b1;
          if (md_rvalid) begin
`ifdef MD_ISSUE_MADD_EN
            if (madd_q) begin
              {hi_q, lo_q} <= acc_sum;
            end else begin
              hi_q <= md_rhi;
              lo_q <= md_rlo;
            end
`else
            hi_q <= md_rhi;
            lo_q <= md_rlo;
`endif
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != StIdle);
    md_req = req_q;
    md_op  = op_q;
    md_a   = a_q;
    md_b   = b_q;
    hi     = hi_q;
    lo     = lo_q;
    div0   = div0_q;
    err    = err_q;
    // Gated by reset so stall reads 0 while reset is held regardless of d_md.
    stall  = reset && d_md && (busy || (e_valid && issue_op));
  end

endmodule

// File: tb/tb_md_issue.sv
// Directed self-checking bench for md_issue; each task checks one scenario inline.
module tb_md_issue;
  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [2:0]  e_op;
  logic [31:0] e_a, e_b;
  logic        d_md;
  logic        md_req;
  logic [1:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        md_ack;
  logic        md_rvalid;
  logic [31:0] md_rhi, md_rlo;
  logic [31:0] hi, lo;
  logic        busy, stall, div0, err;

  int checks = 0;
  int errors = 0;

  md_issue dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op), .e_a(e_a), .e_b(e_b),
    .d_md(d_md), .md_req(md_req), .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .md_ack(md_ack), .md_rvalid(md_rvalid), .md_rhi(md_rhi), .md_rlo(md_rlo),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .div0(div0), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    e_valid = 1'b1; e_op = op; e_a = a; e_b = b;
  endtask

  task automatic test_reset();
    reset = 1'b0; e_valid = 0; e_op = 0; e_a = 0; e_b = 0; d_md = 1'b1;
    md_ack = 0; md_rvalid = 0; md_rhi = 0; md_rlo = 0;
    #12;
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rst_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rst_lo got %h exp 0", lo); end
    checks++; if (md_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", md_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall); end
    checks++; if (div0 !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_flags got %b%b exp 00", div0, err); end
    step();
    reset = 1'b1; d_md = 1'b0;
    step();
  endtask

  task automatic test_mult();
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    step();  // cycle 1
    e_valid = 0;
    checks++; if (md_req !== 1'b1) begin errors++; $display("FAIL mult_req1 got %b exp 1", md_req); end
    checks++; if (md_op !== 2'd0) begin errors++; $display("FAIL mult_op got %0d exp 0", md_op); end
    checks++; if (md_a !== 32'hFFFFFFFE || md_b !== 32'd3) begin
      errors++; $display("FAIL mult_ab got %h %h exp fffffffe 00000003", md_a, md_b); end
    md_ack = 1'b1;
    step();  // cycle 2
    md_ack = 0;
    checks++; if (md_req !== 1'b0) begin errors++; $display("FAIL mult_req2 got %b exp 0", md_req); end
    md_rvalid = 1'b1; md_rhi = 32'hFFFFFFFF; md_rlo = 32'hFFFFFFFA;
    #1;
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mult_prehi got %h exp 0", hi); end
    step();  // cycle 3
    md_rvalid = 0;
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
    checks++; if (busy !== 1'b0 || md_req !== 1'b0) begin
      errors++; $display("FAIL mult_idle got busy %b req %b exp 0 0", busy, md_req); end
  endtask

  task automatic test_div0();
    issue(3'd2, 32'd5, 32'd0);
    step();
    e_valid = 0;
    checks++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_pulse got %b exp 1", div0); end
    checks++; if (md_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL div0_noreq got req %b busy %b exp 0 0", md_req, busy); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL div0_hilo got %h %h exp ffffffff fffffffa", hi, lo); end
    step();
    checks++; if (div0 !== 1'b0 || md_req !== 1'b0) begin
      errors++; $display("FAIL div0_end got div0 %b req %b exp 0 0", div0, md_req); end
  endtask

  task automatic test_divu_stall();
    d_md = 1'b1;
    issue(3'd3, 32'd100, 32'd7);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL divu_stall0 got %b exp 1", stall); end
    step();
    e_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (md_req !== 1'b1 || md_op !== 2'd3 || md_a !== 32'd100 || md_b !== 32'd7
                    || stall !== 1'b1) begin
        errors++; $display("FAIL divu_hold%0d got req %b op %0d a %h b %h stall %b", i, md_req,
                           md_op, md_a, md_b, stall);
      end
      step();
    end
    md_ack = 1'b1;
    step();
    md_ack = 0;
    checks++; if (md_req !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL divu_wait got req %b stall %b exp 0 1", md_req, stall); end
    md_rvalid = 1'b1; md_rhi = 32'd2; md_rlo = 32'd14;
    step();
    md_rvalid = 0;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL divu_stallend got %b exp 0", stall); end
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++; $display("FAIL divu_hilo got %h %h exp 2 e", hi, lo); end
    d_md = 1'b0;
  endtask

  task automatic test_busy_drop();
    issue(3'd1, 32'd3, 32'd4);
    step();  // ISSUE
    issue(3'd5, 32'h55, 32'd0);
    md_rvalid = 1'b1; md_rhi = 32'h99; md_rlo = 32'h99;
    step();
    e_valid = 0; md_rvalid = 0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL drop_err got %b exp 1", err); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++; $display("FAIL drop_hilo got %h %h exp 2 e", hi, lo); end
    checks++; if (md_req !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_state got req %b busy %b exp 1 1", md_req, busy); end
    md_ack = 1'b1;
    step();
    md_ack = 0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL drop_errend got %b exp 0", err); end
    md_rvalid = 1'b1; md_rhi = 32'd0; md_rlo = 32'd12;
    step();
    md_rvalid = 0;
    checks++; if (hi !== 32'd0 || lo !== 32'd12) begin
      errors++; $display("FAIL multu_hilo got %h %h exp 0 c", hi, lo); end
  endtask

  task automatic test_mt();
    issue(3'd4, 32'h12345678, 32'd0);
    step();
    e_valid = 0;
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", hi); end
    checks++; if (lo !== 32'd12) begin errors++; $display("FAIL mthi_lo got %h exp c", lo); end
    checks++; if (busy !== 1'b0 || md_req !== 1'b0) begin
      errors++; $display("FAIL mthi_idle got busy %b req %b exp 0 0", busy, md_req); end
    issue(3'd5, 32'hCAFEBABE, 32'd0);
    step();
    e_valid = 0;
    checks++; if (lo !== 32'hCAFEBABE || hi !== 32'h12345678) begin
      errors++; $display("FAIL mtlo got %h %h exp 12345678 cafebabe", hi, lo); end
  endtask

  task automatic test_reset_wait();
    issue(3'd0, 32'd1, 32'd1);
    step();
    e_valid = 0; md_ack = 1'b1;
    step();  // WAIT
    md_ack = 0;
    reset = 1'b0;
    #1;
    checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || md_req !== 1'b0) begin
      errors++; $display("FAIL rstw_async got %h %h busy %b req %b exp 0 0 0 0", hi, lo, busy, md_req);
    end
    step();
    reset = 1'b1;
    md_rvalid = 1'b1; md_rhi = 32'hAAAAAAAA; md_rlo = 32'hAAAAAAAA;
    step();
    md_rvalid = 0;
    checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstw_ignore got %h %h busy %b exp 0 0 0", hi, lo, busy); end
  endtask

  task automatic test_madd();
    issue(3'd5, 32'd1, 32'd0);
    step();
    e_valid = 0;
    issue(3'd6, 32'd7, 32'd9);
    step();
    e_valid = 0;
`ifdef MD_ISSUE_MADD_EN
    checks++; if (md_req !== 1'b1 || md_op !== 2'd0) begin
      errors++; $display("FAIL madd_req got req %b op %0d exp 1 0", md_req, md_op); end
    md_ack = 1'b1;
    step();
    md_ack = 0;
    md_rvalid = 1'b1; md_rhi = 32'hFFFFFFFF; md_rlo = 32'hFFFFFFFF;
    step();
    md_rvalid = 0;
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL madd_acc got %h %h exp 0 0", hi, lo); end
`else
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL madd_err got %b exp 1", err); end
    checks++; if (md_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL madd_noreq got req %b busy %b exp 0 0", md_req, busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd1) begin
      errors++; $display("FAIL madd_hilo got %h %h exp 0 1", hi, lo); end
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL madd_errend got %b exp 0", err); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div0();
    test_divu_stall();
    test_busy_drop();
    test_mt();
    test_reset_wait();
    test_madd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
